// File: rtl/gpio_uart_rx.sv
// 8N1 UART receiver fed by the MCU GPIO_H0 pin pair, with a one-deep
// valid/ready holding register towards the fabric.
module gpio_uart_rx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       ppm_clk,
   input  logic       ppm_rst,
   input  logic       gpio_h0_out,
   input  logic       gpio_h0_oe_n,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       frame_err,
   output logic       overrun
);

   // Handshake: rx_data is accepted on any rising edge where rx_valid and
   // rx_ready are both high; rx_valid never drops without such a transfer.

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_d1_q;
   logic [CW-1:0]          cnt_q;
   logic [2:0]             idx_q;
   logic [7:0]             shift_q;
   logic                   done_q;

   logic line_raw;
   logic line_s;
   logic line_fall;

   // An undriven pin reads as an idle (high) line.
   assign line_raw  = gpio_h0_oe_n ? 1'b1 : gpio_h0_out;
   assign line_s    = sync_q[SYNC_STAGES-1];
   assign line_fall = line_d1_q & ~line_s;

   always_ff @(posedge ppm_clk) begin
      if (ppm_rst) begin
         sync_q    <= '1;
         line_d1_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], line_raw};
         line_d1_q <= line_s;
      end
   end

   always_ff @(posedge ppm_clk) begin
      if (ppm_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shift_q   <= 8'h00;
         done_q    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         frame_err <= 1'b0;
         case (state_q)
            IDLE: begin
               cnt_q <= '0;
               if (line_fall) state_q <= START;
            end
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  idx_q   <= 3'd0;
                  state_q <= line_s ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q          <= '0;
                  shift_q[idx_q] <= line_s;
                  idx_q          <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == FULL_M1) begin
                  cnt_q     <= '0;
                  state_q   <= IDLE;
                  done_q    <= line_s;
                  frame_err <= ~line_s;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // shift_q is stable for a whole bit time after STOP, so it is loaded here directly.
   always_ff @(posedge ppm_clk) begin
      if (ppm_rst) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (done_q) begin
            if (!rx_valid || rx_ready) begin
               rx_data  <= shift_q;
               rx_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule
